// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state encoding, screen geometry and paddle placement
// used by the ball engine, the display and the paddle logic.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_e;

  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;

  localparam int PADDLE_L_X    = 40;
  localparam int PADDLE_R_X    = 600;
  localparam int PADDLE_W      = 10;
  localparam int PADDLE_H      = 150;
  localparam int PADDLE_L_FACE = PADDLE_L_X + PADDLE_W;

  // Widen an unsigned screen coordinate into the signed 12-bit motion domain.
  function automatic logic signed [11:0] to_s12(input logic [9:0] v);
    return signed'({2'b00, v});
  endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational next-position evaluation: wall bounces, paddle bounces and misses
// for one game step of the ball.
module ball_collide
  import pong_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int BALL_SIZE = 25,
  parameter int SPEED     = 4
) (
  input  logic        [9:0]  ball_x,
  input  logic        [9:0]  ball_y,
  input  logic signed [11:0] vx,
  input  logic signed [11:0] vy,
  input  logic        [9:0]  paddle_l_y,
  input  logic        [9:0]  paddle_r_y,
  output logic        [9:0]  next_x,
  output logic        [9:0]  next_y,
  output logic signed [11:0] next_vx,
  output logic signed [11:0] next_vy,
  output logic               miss_l,
  output logic               miss_r
);

  localparam logic signed [11:0] SPD    = 12'(SPEED);
  localparam logic signed [11:0] BSZ    = 12'(BALL_SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] X_EDGE = 12'(SCREEN_W);
  localparam logic signed [11:0] FACE_R = 12'(PADDLE_R_X);
  localparam logic signed [11:0] FACE_L = 12'(PADDLE_L_FACE);
  localparam logic signed [11:0] PAD_H  = 12'(PADDLE_H);
  localparam logic        [9:0]  Y_MAX_POS = 10'(SCREEN_H - BALL_SIZE);
  localparam logic        [9:0]  HIT_R_POS = 10'(PADDLE_R_X - BALL_SIZE);
  localparam logic        [9:0]  HIT_L_POS = 10'(PADDLE_L_FACE);

  logic signed [11:0] bx, by, nx, ny, pl, pr;
  logic               hit_l, hit_r;

  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    next_vx = vx;
    next_vy = vy;
    bx      = to_s12(ball_x);
    by      = to_s12(ball_y);
    pl      = to_s12(paddle_l_y);
    pr      = to_s12(paddle_r_y);
    nx      = bx + vx;
    ny      = by + vy;
    next_x  = nx[9:0];
    next_y  = ny[9:0];

    hit_r = (vx > 12'sd0) && (bx + BSZ <= FACE_R) && (nx + BSZ >= FACE_R) &&
            (ny + BSZ > pr) && (ny < pr + PAD_H);
    hit_l = (vx < 12'sd0) && (bx >= FACE_L) && (nx <= FACE_L) &&
            (ny + BSZ > pl) && (ny < pl + PAD_H);
    miss_r = !hit_r && !hit_l && (nx + BSZ >= X_EDGE);
    miss_l = !hit_r && !hit_l && (nx <= 12'sd0);

    // Wall and paddle responses are independent, so a corner hit applies both.
    if (ny <= 12'sd0) begin
      next_y  = '0;
      next_vy = SPD;
    end else if (ny >= Y_MAX) begin
      next_y  = Y_MAX_POS;
      next_vy = -SPD;
    end

    if (hit_r) begin
      next_x  = HIT_R_POS;
      next_vx = -SPD;
    end else if (hit_l) begin
      next_x  = HIT_L_POS;
      next_vx = SPD;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Pong game engine: serve/play/point/game-over sequencing, ball motion, scores
// and winner, advanced one step per tick strobe.
module ball_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int BALL_SIZE   = 25,
  parameter int SPEED       = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 50,
  parameter int POINT_HOLD  = 25
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic       point_p1,
  output logic       point_p2,
  output logic [2:0] game_state,
  output logic [1:0] winner
);

  localparam int CNT_MAX = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic        [9:0]       CENTRE_X   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic        [9:0]       CENTRE_Y   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic signed [11:0]      SPD        = 12'(SPEED);
  localparam logic        [3:0]       WIN        = 4'(WIN_SCORE);
  localparam logic        [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY);
  localparam logic        [CNT_W-1:0] HOLD_LOAD  = CNT_W'(POINT_HOLD);
  localparam logic        [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e             state, state_n;
  logic        [9:0]  ball_x_n, ball_y_n;
  logic signed [11:0] vx, vy, vx_n, vy_n;
  logic               serve_left, serve_left_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic        [3:0]  score_one_n, score_two_n;
  logic               point_p1_n, point_p2_n;
  logic        [1:0]  winner_n;

  logic        [9:0]  col_x, col_y;
  logic signed [11:0] col_vx, col_vy;
  logic               col_miss_l, col_miss_r;

  ball_collide #(
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .BALL_SIZE (BALL_SIZE),
    .SPEED     (SPEED)
  ) u_collide (
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .vx         (vx),
    .vy         (vy),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .next_x     (col_x),
    .next_y     (col_y),
    .next_vx    (col_vx),
    .next_vy    (col_vy),
    .miss_l     (col_miss_l),
    .miss_r     (col_miss_r)
  );

  assign game_state = state;

  always_comb begin
    state_n      = state;
    ball_x_n     = ball_x;
    ball_y_n     = ball_y;
    vx_n         = vx;
    vy_n         = vy;
    serve_left_n = serve_left;
    cnt_n        = cnt;
    score_one_n  = score_one;
    score_two_n  = score_two;
    winner_n     = winner;
    point_p1_n   = 1'b0;
    point_p2_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        ball_x_n = CENTRE_X;
        ball_y_n = CENTRE_Y;
        if (serve) begin
          cnt_n   = SERVE_LOAD;
          state_n = ST_SERVE_WAIT;
        end
      end

      ST_SERVE_WAIT: if (tick) begin
        if (cnt <= CNT_ONE) begin
          cnt_n   = '0;
          vx_n    = serve_left ? -SPD : SPD;
          vy_n    = SPD;
          state_n = ST_PLAY;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      ST_PLAY: if (tick) begin
        // A miss freezes the ball where it was; the loser of the point serves.
        if (col_miss_r) begin
          if (score_one < WIN) score_one_n = score_one + 4'd1;
          point_p1_n   = 1'b1;
          serve_left_n = 1'b0;
          cnt_n        = HOLD_LOAD;
          state_n      = ST_POINT;
        end else if (col_miss_l) begin
          if (score_two < WIN) score_two_n = score_two + 4'd1;
          point_p2_n   = 1'b1;
          serve_left_n = 1'b1;
          cnt_n        = HOLD_LOAD;
          state_n      = ST_POINT;
        end else begin
          ball_x_n = col_x;
          ball_y_n = col_y;
          vx_n     = col_vx;
          vy_n     = col_vy;
        end
      end

      ST_POINT: if (tick) begin
        if (cnt <= CNT_ONE) begin
          ball_x_n = CENTRE_X;
          ball_y_n = CENTRE_Y;
          if (score_one == WIN || score_two == WIN) begin
            cnt_n    = '0;
            winner_n = (score_one == WIN) ? 2'b01 : 2'b10;
            state_n  = ST_GAME_OVER;
          end else begin
            cnt_n   = SERVE_LOAD;
            state_n = ST_SERVE_WAIT;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      ST_GAME_OVER: begin
        ball_x_n = CENTRE_X;
        ball_y_n = CENTRE_Y;
        if (serve) begin
          score_one_n = '0;
          score_two_n = '0;
          winner_n    = 2'b00;
          state_n     = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= ST_IDLE;
      ball_x     <= CENTRE_X;
      ball_y     <= CENTRE_Y;
      vx         <= SPD;
      vy         <= SPD;
      serve_left <= 1'b0;
      cnt        <= '0;
      score_one  <= '0;
      score_two  <= '0;
      point_p1   <= 1'b0;
      point_p2   <= 1'b0;
      winner     <= 2'b00;
    end else begin
      state      <= state_n;
      ball_x     <= ball_x_n;
      ball_y     <= ball_y_n;
      vx         <= vx_n;
      vy         <= vy_n;
      serve_left <= serve_left_n;
      cnt        <= cnt_n;
      score_one  <= score_one_n;
      score_two  <= score_two_n;
      point_p1   <= point_p1_n;
      point_p2   <= point_p2_n;
      winner     <= winner_n;
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: collision cases on ball_collide, then full
// rallies through serve, wall/paddle bounces, points, game over and reset.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       reset, tick, serve;
  logic [9:0] paddle_l_y, paddle_r_y;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_one, score_two;
  logic       point_p1, point_p2;
  logic [2:0] game_state;
  logic [1:0] winner;

  logic        [9:0]  c_bx, c_by, c_pl, c_pr, c_nx, c_ny;
  logic signed [11:0] c_vx, c_vy, c_nvx, c_nvy;
  logic               c_miss_l, c_miss_r;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  ball_engine dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .tick          (tick),
    .serve         (serve),
    .paddle_l_y    (paddle_l_y),
    .paddle_r_y    (paddle_r_y),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .score_one     (score_one),
    .score_two     (score_two),
    .point_p1      (point_p1),
    .point_p2      (point_p2),
    .game_state    (game_state),
    .winner        (winner)
  );

  ball_collide u_col (
    .ball_x     (c_bx),
    .ball_y     (c_by),
    .vx         (c_vx),
    .vy         (c_vy),
    .paddle_l_y (c_pl),
    .paddle_r_y (c_pr),
    .next_x     (c_nx),
    .next_y     (c_ny),
    .next_vx    (c_nvx),
    .next_vy    (c_nvy),
    .miss_l     (c_miss_l),
    .miss_r     (c_miss_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step_tick();
  endtask

  task automatic pulse_serve();
    @(negedge clk); serve = 1'b1;
    @(negedge clk); serve = 1'b0;
  endtask

  // Serve to the left from centre; the ball misses the left paddle on play tick 77.
  task automatic left_rally(input int score);
    ticks(50);
    step_tick();
    check("left_first_x", ball_x, 303);
    ticks(75);
    check("left_pre_miss_x", ball_x, 3);
    step_tick();
    check("left_miss_pulse", point_p2, 1);
    check("left_miss_score", score_two, score);
    ticks(25);
    check("left_reserve_state", game_state, 1);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; serve = 1'b0;
    paddle_l_y = 10'd200; paddle_r_y = 10'd0;

    // Direct collision cases.
    c_bx = 10'd300; c_by = 10'd2; c_vx = 12'sd4; c_vy = -12'sd4; c_pl = 10'd200; c_pr = 10'd0;
    #1;
    check("top_wall_y", c_ny, 0);
    check("top_wall_vy", c_nvy, 4);
    check("top_wall_x", c_nx, 304);
    check("top_wall_nomiss", {c_miss_l, c_miss_r}, 0);
    c_bx = 10'd573; c_by = 10'd200; c_vx = 12'sd4; c_vy = 12'sd4; c_pr = 10'd150;
    #1;
    check("rpad_x", c_nx, 575);
    check("rpad_vx", c_nvx, -4);
    check("rpad_y", c_ny, 204);
    c_by = 10'd453; c_pr = 10'd350;
    #1;
    check("corner_x", c_nx, 575);
    check("corner_vx", c_nvx, -4);
    check("corner_y", c_ny, 455);
    check("corner_vy", c_nvy, -4);
    c_bx = 10'd52; c_by = 10'd120; c_vx = -12'sd4; c_vy = -12'sd4; c_pl = 10'd100;
    #1;
    check("lpad_x", c_nx, 50);
    check("lpad_vx", c_nvx, 4);
    check("lpad_y", c_ny, 116);
    c_bx = 10'd612; c_by = 10'd400; c_vx = 12'sd4; c_vy = 12'sd4; c_pr = 10'd0;
    #1;
    check("rmiss", c_miss_r, 1);
    c_bx = 10'd3; c_by = 10'd300; c_vx = -12'sd4; c_pl = 10'd0;
    #1;
    check("lmiss", c_miss_l, 1);

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_state", game_state, 0);
    check("rst_x", ball_x, 307);
    check("rst_y", ball_y, 227);
    check("rst_scores", {score_one, score_two}, 0);
    check("rst_winner", winner, 0);
    check("rst_pulses", {point_p1, point_p2}, 0);

    // Rally 1: serve right, bottom bounce, miss right paddle.
    pulse_serve();
    check("serve_wait", game_state, 1);
    ticks(49);
    check("still_wait", game_state, 1);
    step_tick();
    check("play_entered", game_state, 2);
    check("play_x0", ball_x, 307);
    pulse_serve();
    check("serve_ign_play", game_state, 2);
    step_tick();
    check("first_tick_x", ball_x, 311);
    check("first_tick_y", ball_y, 231);
    ticks(56);
    check("bottom_clamp", ball_y, 455);
    step_tick();
    check("bottom_rebound", ball_y, 451);
    ticks(18);
    check("pre_miss_x", ball_x, 611);
    check("pre_miss_y", ball_y, 379);
    check("pre_miss_nopulse", point_p1, 0);
    step_tick();
    check("p1_pulse", point_p1, 1);
    check("p1_score", score_one, 1);
    check("point_state", game_state, 3);
    check("point_frozen_x", ball_x, 611);
    @(negedge clk);
    check("p1_pulse_end", point_p1, 0);
    pulse_serve();
    check("serve_ign_point", game_state, 3);
    ticks(24);
    check("hold_state", game_state, 3);
    step_tick();
    check("hold_done", game_state, 1);
    check("recentre_x", ball_x, 307);
    check("recentre_y", ball_y, 227);

    // Rally 2: right paddle returns the ball, top bounce, miss left paddle.
    paddle_r_y = 10'd300;
    ticks(50);
    check("r2_play", game_state, 2);
    ticks(66);
    check("r2_pre_hit_x", ball_x, 571);
    step_tick();
    check("r2_hit_x", ball_x, 575);
    check("r2_hit_y", ball_y, 415);
    step_tick();
    check("r2_return_x", ball_x, 571);
    ticks(102);
    check("r2_pre_top_y", ball_y, 3);
    step_tick();
    check("r2_top_y", ball_y, 0);
    step_tick();
    check("r2_top_rebound", ball_y, 4);
    check("r2_x", ball_x, 155);
    ticks(38);
    check("r2_pre_miss_x", ball_x, 3);
    step_tick();
    check("p2_pulse", point_p2, 1);
    check("p2_score", score_two, 1);
    check("p1_score_held", score_one, 1);
    ticks(25);
    check("r2_reserve", game_state, 1);

    // Left misses until player 2 reaches 8, then the winning point.
    for (int s = 2; s <= 8; s++) left_rally(s);
    ticks(50);
    ticks(76);
    step_tick();
    check("win_pulse", point_p2, 1);
    check("win_score", score_two, 9);
    check("win_point_state", game_state, 3);
    ticks(24);
    check("win_hold", game_state, 3);
    step_tick();
    check("game_over", game_state, 4);
    check("winner_p2", winner, 2);
    check("go_x", ball_x, 307);
    check("go_y", ball_y, 227);
    check("go_scores", {score_one, score_two}, {4'd1, 4'd9});
    step_tick();
    check("go_hold", game_state, 4);
    pulse_serve();
    check("go_to_idle", game_state, 0);
    check("go_cleared", {score_one, score_two}, 0);
    check("go_winner_clr", winner, 0);

    // Reset together with the tick that would score a left miss.
    pulse_serve();
    ticks(50);
    ticks(76);
    check("mid_play_x", ball_x, 3);
    @(negedge clk); reset = 1'b1; tick = 1'b1;
    @(negedge clk); reset = 1'b0; tick = 1'b0;
    check("rst2_state", game_state, 0);
    check("rst2_x", ball_x, 307);
    check("rst2_y", ball_y, 227);
    check("rst2_nopulse", {point_p1, point_p2}, 0);
    check("rst2_scores", {score_one, score_two}, 0);
    pulse_serve();
    ticks(50);
    step_tick();
    check("rst2_dir_x", ball_x, 311);
    check("rst2_dir_y", ball_y, 231);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 SHALL have parameter BALL_SIZE, default 25, ball side length in pixels.
REQ-004 SHALL have parameter SPEED, default 4, ball speed per axis in pixels per tick.
REQ-005 SHALL have parameter WIN_SCORE, default 9, points needed to win a game.
REQ-006 SHALL have parameter SERVE_DELAY, default 50, ticks between serve request and launch.
REQ-007 SHALL have parameter POINT_HOLD, default 25, ticks the ball stays frozen after a point.
REQ-008 MAX10_CLK1_50  in  1  sole clock; all state updates on its rising edge.
REQ-009 reset  in  1  synchronous reset, active-high.
REQ-010 tick  in  1  one-cycle game-step strobe from the clock divider.
REQ-011 serve  in  1  one-cycle serve request, already debounced.
REQ-012 paddle_l_y  in  10  left paddle top row.
REQ-013 paddle_r_y  in  10  right paddle top row.
REQ-014 ball_x  out  10  ball left column.
REQ-015 ball_y  out  10  ball top row.
REQ-016 score_one  out  4  player-1 (left) score, BCD digit for the HEX display.
REQ-017 score_two  out  4  player-2 (right) score, BCD digit.
REQ-018 point_p1, point_p2  out  1 each  one-cycle pulse when the named player scores.
REQ-019 game_state  out  3  current FSM state encoding.
REQ-020 winner  out  2  00 none, 01 P1, 10 P2.

Function
REQ-021 FSM states SHALL be IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER; all other logic SHALL hold except on tick, apart from the serve transitions.
REQ-022 IDLE: ball centred at (307,227) for the defaults; on serve SHALL load the delay counter with SERVE_DELAY and go to SERVE_WAIT.
REQ-023 SERVE_WAIT: each tick decrements the counter; on the tick where it reaches 0, SHALL enter PLAY with vy=+SPEED and vx taken from the serve_dir register.
REQ-024 PLAY, per tick: nx=ball_x+vx and ny=ball_y+vy, computed in signed 12-bit arithmetic.
REQ-025 Top wall: if ny<=0, SHALL set ball_y=0 and vy=+SPEED.
REQ-026 Bottom wall: if ny>=SCREEN_H-BALL_SIZE, SHALL clamp ball_y to that value and set vy=-SPEED.
REQ-027 Right paddle: face column is 600 and paddle height is 150.
  - Condition: vx>0, ball_x+BALL_SIZE<=600, nx+BALL_SIZE>=600, and rows overlap (ny+BALL_SIZE>paddle_r_y and ny<paddle_r_y+150).
  - Response: SHALL set ball_x=600-BALL_SIZE and vx=-SPEED.
REQ-028 Left paddle: face column is 50 (x=40, width 10).
  - Condition: vx<0, ball_x>=50, nx<=50, and rows overlap with paddle_l_y.
  - Response: SHALL set ball_x=50 and vx=+SPEED.
REQ-029 A wall bounce and a paddle bounce in the same tick SHALL both apply (corner hit).
REQ-030 Right miss: if there is no paddle hit and nx+BALL_SIZE>=SCREEN_W:
  - score_one SHALL increment and point_p1 SHALL pulse;
  - serve_dir SHALL be set to +1;
  - the FSM SHALL go to POINT.
REQ-031 Left miss: if there is no paddle hit and nx<=0:
  - score_two SHALL increment and point_p2 SHALL pulse;
  - serve_dir SHALL be set to -1;
  - the FSM SHALL go to POINT.
REQ-032 POINT: ball frozen at its last position for POINT_HOLD ticks.
  - If the new score equals WIN_SCORE: SHALL go to GAME_OVER with winner set.
  - Otherwise: SHALL re-centre the ball and go to SERVE_WAIT with the counter reloaded.
REQ-033 GAME_OVER: ball centred, scores held; serve SHALL clear the scores and winner and go to IDLE.
REQ-034 Scores SHALL never exceed WIN_SCORE; no wrap-around.
REQ-035 All outputs SHALL be registered; position and score update in the cycle after the tick edge.
REQ-036 Paddle inputs SHALL be sampled on the tick cycle only.
REQ-037 serve SHALL be ignored in SERVE_WAIT, PLAY and POINT.

Reset
REQ-038 Reset SHALL dominate tick and serve in the same cycle, including mid-PLAY.
REQ-039 On reset: state=IDLE, ball at centre, vx=+SPEED, vy=+SPEED, serve_dir=+1, scores=0, pulses=0, winner=00, counter=0.

Structure
REQ-040 Package pong_pkg SHALL hold the state enum, the screen geometry, and the paddle x/width/height constants shared with the display and paddle logic.
REQ-041 Combinational next-position and bounce evaluation SHALL live in one sub-module, ball_collide; the FSM, counters and scores SHALL stay in ball_engine.

Verification
REQ-042 Reset, then serve, then 50 ticks: PLAY entered, ball_x=311, ball_y=231 after the first PLAY tick.
REQ-043 Ball at y=2 with vy=-4, one tick: ball_y=0, vy=+4; no point pulse.
REQ-044 paddle_r_y=150, ball at (573,200) with vx=+4, one tick: ball_x=575, vx=-4.
REQ-045 paddle_r_y=0, ball at (612,400) moving right, one tick: point_p1 pulses once, score_one 0->1, POINT entered, then SERVE_WAIT after 25 ticks.
REQ-046 score_two=8 with a left miss: score_two=9, GAME_OVER, winner=10; serve then returns to IDLE with both scores 0.
REQ-047 Reset asserted in the same cycle as tick mid-PLAY: all REQ-039 values next cycle; no point pulse.
